// File: rtl/mem_cell_arbiter.sv
// -----------------------------------------------------------------------------
// mem_cell_arbiter
//
// Shares a single mem_cell (buffer / FIFO / LIFO storage with one-hot mode and
// chip enable, 2-bit rw) between NREQ requesters. Requesters are granted
// round-robin. Each accepted request is checked against the mem_cell status
// and the currently configured mode. A request for a different mode is only
// honoured when the mem_cell is empty. In that case the mem_cell is flushed
// through its reset while the new mode is presented. Only one transaction is
// in flight at a time.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous active-low reset
//   req_valid    per-requester request pending
//   req_rw       per-requester 2-bit op (01 write, 10 read)
//   req_mode     per-requester one-hot mode (001 buffer, 010 FIFO, 100 LIFO)
//   req_din      per-requester write data
//   req_ready    one-cycle accept pulse to the granted requester
//   rsp_valid    one-cycle completion pulse to the owning requester
//   rsp_data     read data, qualified by rsp_valid
//   rsp_err      request rejected, qualified by rsp_valid
//   mem_Din      write data to the mem_cell
//   mem_mode_in  mode to the mem_cell
//   mem_chip_en  chip enable to the mem_cell
//   mem_rw       rw command to the mem_cell
//   mem_reset    active-high reset to the mem_cell
//   mem_Dout     read data from the mem_cell
//   mem_full     full flag from the mem_cell
//   mem_empty    empty flag from the mem_cell
// -----------------------------------------------------------------------------
module mem_cell_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_rw,
  input  logic [3*NREQ-1:0]       req_mode,
  input  logic [WIDTH*NREQ-1:0]   req_din,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic [WIDTH-1:0]        mem_Din,
  output logic [2:0]              mem_mode_in,
  output logic [2:0]              mem_chip_en,
  output logic [1:0]              mem_rw,
  output logic                    mem_reset,
  input  logic [WIDTH-1:0]        mem_Dout,
  input  logic                    mem_full,
  input  logic                    mem_empty
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CHECK,
    ST_SWITCH,
    ST_EXEC,
    ST_WAIT_RD,
    ST_RESP
  } state_t;

  state_t            state_q,    state_d;
  logic [2:0]        cur_mode_q, cur_mode_d;
  logic [IDXW-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [IDXW-1:0]   idx_q,      idx_d;
  logic [1:0]        rw_q,       rw_d;
  logic [2:0]        mode_q,     mode_d;
  logic [WIDTH-1:0]  din_q,      din_d;
  logic              err_q,      err_d;
  logic [WIDTH-1:0]  rd_data_q,  rd_data_d;

  logic [1:0]        rw_arr   [NREQ];
  logic [2:0]        mode_arr [NREQ];
  logic [WIDTH-1:0]  din_arr  [NREQ];

  logic              grant_found;
  logic [IDXW-1:0]   grant_idx;

  logic              mode_ok;
  logic              rw_ok;

  // Split the flat per-requester buses into arrays so the granted payload can
  // be selected by index.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign rw_arr[g]   = req_rw[2*g +: 2];
    assign mode_arr[g] = req_mode[3*g +: 3];
    assign din_arr[g]  = req_din[WIDTH*g +: WIDTH];
  end

  // Round-robin pick: the first pending requester found scanning upward from
  // the one after the last grant, wrapping at NREQ. Scanning NREQ positions
  // ends on rr_ptr itself, so a lone requester can be granted back to back.
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!grant_found && req_valid[cand[IDXW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDXW-1:0];
      end
    end
  end

  // Legality of the latched request, independent of the mem_cell status.
  assign mode_ok = (mode_q == 3'b001) || (mode_q == 3'b010) || (mode_q == 3'b100);
  assign rw_ok   = (rw_q == RW_WRITE) || (rw_q == RW_READ);

  // State and transaction registers. Dropping into INIT on reset abandons any
  // in-flight transaction without a response, and rr_ptr restarts at the last
  // requester so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      cur_mode_q <= 3'b000;
      rr_ptr_q   <= IDXW'(NREQ - 1);
      idx_q      <= '0;
      rw_q       <= 2'b00;
      mode_q     <= 3'b000;
      din_q      <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      rw_q       <= rw_d;
      mode_q     <= mode_d;
      din_q      <= din_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Next-state and output logic. Outputs are decoded purely from the current
  // state and latched request, so every mem_cell command and response lasts
  // exactly one cycle. The mem_cell status flags only matter in CHECK.
  always_comb begin
    state_d     = state_q;
    cur_mode_d  = cur_mode_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    rw_d        = rw_q;
    mode_d      = mode_q;
    din_d       = din_q;
    err_d       = err_q;
    rd_data_d   = rd_data_q;

    req_ready   = '0;
    rsp_valid   = '0;
    rsp_data    = '0;
    rsp_err     = 1'b0;
    mem_Din     = '0;
    mem_mode_in = cur_mode_q;
    mem_chip_en = 3'b000;
    mem_rw      = 2'b00;
    mem_reset   = ~reset;

    unique case (state_q)
      ST_INIT: begin
        mem_reset = 1'b1;
        state_d   = ST_IDLE;
      end

      ST_IDLE: begin
        if (grant_found) begin
          req_ready = NREQ'(1) << grant_idx;
          idx_d     = grant_idx;
          rr_ptr_d  = grant_idx;
          rw_d      = rw_arr[grant_idx];
          mode_d    = mode_arr[grant_idx];
          din_d     = din_arr[grant_idx];
          err_d     = 1'b0;
          rd_data_d = '0;
          state_d   = ST_CHECK;
        end
      end

      // A malformed request is rejected before anything else. A mode change
      // must not destroy stored data, so it is refused unless the mem_cell is
      // empty. The full/empty checks only apply when staying in the same mode.
      ST_CHECK: begin
        if (!mode_ok || !rw_ok) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (mode_q != cur_mode_q) begin
          if (!mem_empty) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_SWITCH;
          end
        end else if ((rw_q == RW_WRITE) && mem_full) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if ((rw_q == RW_READ) && mem_empty) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_EXEC;
        end
      end

      // The mem_cell picks up its new mode while held in reset.
      ST_SWITCH: begin
        mem_reset   = 1'b1;
        mem_mode_in = mode_q;
        cur_mode_d  = mode_q;
        state_d     = ST_EXEC;
      end

      ST_EXEC: begin
        mem_chip_en = cur_mode_q;
        mem_rw      = rw_q;
        mem_Din     = din_q;
        state_d     = (rw_q == RW_READ) ? ST_WAIT_RD : ST_RESP;
      end

      // The mem_cell registers its read data on the read edge, so Dout is
      // only valid during the following cycle.
      ST_WAIT_RD: begin
        mem_chip_en = cur_mode_q;
        rd_data_d   = mem_Dout;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid = NREQ'(1) << idx_q;
        rsp_err   = err_q;
        rsp_data  = rd_data_q;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_cell_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_cell_arbiter
//
// Bench for mem_cell_arbiter with a behavioural mem_cell attached (buffer of
// one entry, FIFO and LIFO of four entries, read data registered on the read
// edge, cleared by mem_reset).
// -----------------------------------------------------------------------------
module tb_mem_cell_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_rw;
  logic [3*NREQ-1:0]     req_mode;
  logic [WIDTH*NREQ-1:0] req_din;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
  logic [WIDTH-1:0]      mem_Din;
  logic [2:0]            mem_mode_in;
  logic [2:0]            mem_chip_en;
  logic [1:0]            mem_rw;
  logic                  mem_reset;
  logic [WIDTH-1:0]      mem_Dout;
  logic                  mem_full;
  logic                  mem_empty;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  mem_cell_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_mode   (req_mode),
    .req_din    (req_din),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .mem_Din    (mem_Din),
    .mem_mode_in(mem_mode_in),
    .mem_chip_en(mem_chip_en),
    .mem_rw     (mem_rw),
    .mem_reset  (mem_reset),
    .mem_Dout   (mem_Dout),
    .mem_full   (mem_full),
    .mem_empty  (mem_empty)
  );

  // Behavioural mem_cell.
  logic [WIDTH-1:0] memStore [$];
  int               memCount = 0;
  logic [WIDTH-1:0] memDoutQ = '0;
  logic [WIDTH-1:0] popVal;

  function automatic int capFor(input logic [2:0] m);
    return (m == 3'b001) ? 1 : 4;
  endfunction

  always @(posedge clk or posedge mem_reset) begin
    if (mem_reset) begin
      memStore.delete();
      memCount = 0;
      memDoutQ <= '0;
    end else if (mem_chip_en != 3'b000) begin
      if (mem_rw == 2'b01) begin
        if (memCount < capFor(mem_mode_in)) begin
          memStore.push_back(mem_Din);
          memCount = memCount + 1;
        end
      end else if (mem_rw == 2'b10) begin
        if (memCount == 0) begin
          memDoutQ <= '0;
        end else begin
          if (mem_mode_in == 3'b100) popVal = memStore.pop_back();
          else                       popVal = memStore.pop_front();
          memCount = memCount - 1;
          memDoutQ <= popVal;
        end
      end
    end
  end

  assign mem_Dout  = memDoutQ;
  assign mem_empty = (memCount == 0);
  assign mem_full  = (memCount >= capFor(mem_mode_in));

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One transaction: present the request set, wait for a grant, then follow it
  // to its response while counting mem_reset and mem_rw activity.
  task automatic applyStimulus(
    input  logic [NREQ-1:0]       mask,
    input  logic [2*NREQ-1:0]     rwBus,
    input  logic [3*NREQ-1:0]     modeBus,
    input  logic [WIDTH*NREQ-1:0] dinBus,
    output logic [NREQ-1:0]       grantVec,
    output logic [NREQ-1:0]       rspVec,
    output logic                  err,
    output logic [WIDTH-1:0]      data,
    output int                    lat,
    output int                    resets,
    output int                    rwCycles
  );
    int waitCnt;
    @(negedge clk);
    req_valid = mask;
    req_rw    = rwBus;
    req_mode  = modeBus;
    req_din   = dinBus;
    #1;
    waitCnt = 0;
    while (req_ready == '0 && waitCnt < 30) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    grantVec = req_ready;
    rspVec   = '0;
    err      = 1'b0;
    data     = '0;
    lat      = 0;
    resets   = 0;
    rwCycles = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      req_valid = '0;
      #1;
      if (mem_reset) resets++;
      if (mem_rw != 2'b00) rwCycles++;
      if (rsp_valid != '0) begin
        rspVec = rsp_valid;
        err    = rsp_err;
        data   = rsp_data;
        break;
      end
    end
  endtask

  typedef struct {
    int               reqIdx;
    logic [1:0]       rw;
    logic [2:0]       mode;
    logic [WIDTH-1:0] din;
    logic             expErr;
    logic [WIDTH-1:0] expData;
    int               expLat;
    int               expResets;
    int               expRwCycles;
    logic [2:0]       expCurMode;
  } vec_t;

  function automatic vec_t mkVec(input int r, input logic [1:0] rw, input logic [2:0] mode,
                                 input logic [WIDTH-1:0] din, input logic e, input logic [WIDTH-1:0] d,
                                 input int l, input int rs, input int rc, input logic [2:0] cm);
    vec_t v;
    v.reqIdx = r; v.rw = rw; v.mode = mode; v.din = din; v.expErr = e; v.expData = d;
    v.expLat = l; v.expResets = rs; v.expRwCycles = rc; v.expCurMode = cm;
    return v;
  endfunction

  // Reference model for random traffic: storage as a queue, plus mode and
  // round-robin pointer.
  logic [WIDTH-1:0] modelQ [$];
  logic [2:0]       modelCur;
  int               modelRr;

  task automatic modelTxn(input logic [1:0] rw, input logic [2:0] mode, input logic [WIDTH-1:0] din,
                          output logic err, output logic [WIDTH-1:0] data, output int lat);
    logic oneHot;
    logic rwOk;
    int   sw;
    oneHot = (mode == 3'b001) || (mode == 3'b010) || (mode == 3'b100);
    rwOk   = (rw == 2'b01) || (rw == 2'b10);
    err = 1'b0; data = '0; lat = 2; sw = 0;
    if (!oneHot || !rwOk) begin
      err = 1'b1;
    end else if (mode != modelCur && modelQ.size() != 0) begin
      err = 1'b1;
    end else begin
      if (mode != modelCur) begin
        modelQ.delete();
        modelCur = mode;
        sw = 1;
      end else if (rw == 2'b01 && modelQ.size() >= capFor(modelCur)) begin
        err = 1'b1;
      end else if (rw == 2'b10 && modelQ.size() == 0) begin
        err = 1'b1;
      end
      if (!err) begin
        if (rw == 2'b01) begin
          modelQ.push_back(din);
          lat = 3 + sw;
        end else begin
          if (modelQ.size() == 0)        data = '0;
          else if (modelCur == 3'b100)   data = modelQ.pop_back();
          else                           data = modelQ.pop_front();
          lat = 4 + sw;
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t                  vecs [$];
    logic [NREQ-1:0]       grantVec, rspVec, mask;
    logic                  gotErr, expErr;
    logic [WIDTH-1:0]      gotData, expData;
    int                    gotLat, expLat, gotResets, gotRw, got, cycles, expIdx;
    logic [2*NREQ-1:0]     rwBus;
    logic [3*NREQ-1:0]     modeBus;
    logic [WIDTH*NREQ-1:0] dinBus;
    logic [NREQ-1:0]       rrGrants [5];
    logic [NREQ-1:0]       rrExpect [5];

    reset     = 1'b1;
    req_valid = '0;
    req_rw    = '0;
    req_mode  = '0;
    req_din   = '0;

    // Reset held for two cycles with requests pending.
    #2;
    reset     = 1'b0;
    req_valid = '1;
    req_rw    = {NREQ{2'b01}};
    req_mode  = {NREQ{3'b010}};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("rst%0d.req_ready", c), 64'(req_ready), 64'(0));
      checkOutput($sformatf("rst%0d.rsp", c), {rsp_valid, rsp_err, rsp_data}, 64'(0));
      checkOutput($sformatf("rst%0d.memOut", c), {mem_Din, mem_mode_in, mem_chip_en, mem_rw}, 64'(0));
      checkOutput($sformatf("rst%0d.mem_reset", c), 64'(mem_reset), 64'(1));
    end
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b1;
    #1;
    checkOutput("init.mem_reset", 64'(mem_reset), 64'(1));
    @(negedge clk);
    #1;
    checkOutput("idle.mem_reset", 64'(mem_reset), 64'(0));

    // All requesters hold malformed requests: grants rotate 0,1,2,3,0.
    @(negedge clk);
    req_valid = '1;
    req_rw    = '1;
    req_mode  = {NREQ{3'b001}};
    req_din   = '0;
    got = 0; cycles = 0;
    for (int g = 0; g < 5; g++) rrGrants[g] = '0;
    while (got < 5 && cycles < 100) begin
      #1;
      if (req_ready != '0) begin
        rrGrants[got] = req_ready;
        got++;
      end
      @(negedge clk);
      cycles++;
    end
    req_valid = '0;
    rrExpect[0] = 4'b0001; rrExpect[1] = 4'b0010; rrExpect[2] = 4'b0100;
    rrExpect[3] = 4'b1000; rrExpect[4] = 4'b0001;
    for (int g = 0; g < 5; g++) begin
      checkOutput($sformatf("rr.grant%0d", g), 64'(rrGrants[g]), 64'(rrExpect[g]));
    end

    // Directed transaction table.
    vecs.push_back(mkVec(0, 2'b01, 3'b010, 1, 0, 0, 4, 1, 1, 3'b010));
    vecs.push_back(mkVec(0, 2'b01, 3'b010, 2, 0, 0, 3, 0, 1, 3'b010));
    vecs.push_back(mkVec(0, 2'b01, 3'b010, 3, 0, 0, 3, 0, 1, 3'b010));
    vecs.push_back(mkVec(0, 2'b10, 3'b010, 0, 0, 1, 4, 0, 1, 3'b010));
    vecs.push_back(mkVec(0, 2'b10, 3'b010, 0, 0, 2, 4, 0, 1, 3'b010));
    vecs.push_back(mkVec(0, 2'b10, 3'b010, 0, 0, 3, 4, 0, 1, 3'b010));
    vecs.push_back(mkVec(1, 2'b01, 3'b100, 1, 0, 0, 4, 1, 1, 3'b100));
    vecs.push_back(mkVec(1, 2'b01, 3'b100, 2, 0, 0, 3, 0, 1, 3'b100));
    vecs.push_back(mkVec(1, 2'b01, 3'b100, 3, 0, 0, 3, 0, 1, 3'b100));
    vecs.push_back(mkVec(1, 2'b10, 3'b100, 0, 0, 3, 4, 0, 1, 3'b100));
    vecs.push_back(mkVec(1, 2'b10, 3'b100, 0, 0, 2, 4, 0, 1, 3'b100));
    vecs.push_back(mkVec(1, 2'b10, 3'b100, 0, 0, 1, 4, 0, 1, 3'b100));
    vecs.push_back(mkVec(1, 2'b10, 3'b100, 0, 1, 0, 2, 0, 0, 3'b100));
    vecs.push_back(mkVec(2, 2'b01, 3'b010, 7, 0, 0, 4, 1, 1, 3'b010));
    vecs.push_back(mkVec(2, 2'b01, 3'b100, 9, 1, 0, 2, 0, 0, 3'b010));
    vecs.push_back(mkVec(2, 2'b10, 3'b010, 0, 0, 7, 4, 0, 1, 3'b010));
    vecs.push_back(mkVec(3, 2'b01, 3'b001, 5, 0, 0, 4, 1, 1, 3'b001));
    vecs.push_back(mkVec(3, 2'b01, 3'b001, 6, 1, 0, 2, 0, 0, 3'b001));
    vecs.push_back(mkVec(0, 2'b01, 3'b110, 8, 1, 0, 2, 0, 0, 3'b001));
    vecs.push_back(mkVec(0, 2'b11, 3'b001, 8, 1, 0, 2, 0, 0, 3'b001));
    vecs.push_back(mkVec(0, 2'b00, 3'b001, 8, 1, 0, 2, 0, 0, 3'b001));
    vecs.push_back(mkVec(3, 2'b10, 3'b001, 0, 0, 5, 4, 0, 1, 3'b001));

    foreach (vecs[i]) begin
      mask    = NREQ'(1) << vecs[i].reqIdx;
      rwBus   = '0;
      modeBus = '0;
      dinBus  = '0;
      rwBus[2*vecs[i].reqIdx +: 2]         = vecs[i].rw;
      modeBus[3*vecs[i].reqIdx +: 3]       = vecs[i].mode;
      dinBus[WIDTH*vecs[i].reqIdx +: WIDTH] = vecs[i].din;
      applyStimulus(mask, rwBus, modeBus, dinBus, grantVec, rspVec, gotErr, gotData, gotLat, gotResets, gotRw);
      checkOutput($sformatf("vec%0d.grant", i), 64'(grantVec), 64'(mask));
      checkOutput($sformatf("vec%0d.rspValid", i), 64'(rspVec), 64'(mask));
      checkOutput($sformatf("vec%0d.err", i), 64'(gotErr), 64'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d.data", i), 64'(gotData), 64'(vecs[i].expData));
      checkOutput($sformatf("vec%0d.latency", i), 64'(gotLat), 64'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d.memResets", i), 64'(gotResets), 64'(vecs[i].expResets));
      checkOutput($sformatf("vec%0d.memRwCycles", i), 64'(gotRw), 64'(vecs[i].expRwCycles));
      checkOutput($sformatf("vec%0d.curMode", i), 64'(mem_mode_in), 64'(vecs[i].expCurMode));
    end

    // Reset during WAIT_RD drops the read without a response.
    rwBus = '0; modeBus = '0; dinBus = '0;
    rwBus[3:2] = 2'b01; modeBus[5:3] = 3'b001; dinBus[2*WIDTH-1:WIDTH] = 32'h55;
    applyStimulus(4'b0010, rwBus, modeBus, dinBus, grantVec, rspVec, gotErr, gotData, gotLat, gotResets, gotRw);
    checkOutput("wrd.setupErr", 64'(gotErr), 64'(0));
    @(negedge clk);
    req_valid = 4'b0010;
    req_rw    = 8'b0000_1000;
    req_mode  = 12'b000_000_001_000;
    #1;
    cycles = 0;
    while (req_ready == '0 && cycles < 30) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    checkOutput("wrd.grant", 64'(req_ready), 64'(4'b0010));
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checkOutput("wrd.execRw", 64'(mem_rw), 64'(2'b10));
    @(negedge clk);
    #1;
    checkOutput("wrd.waitChipEn", 64'(mem_chip_en), 64'(3'b001));
    reset = 1'b0;
    #1;
    checkOutput("wrd.rstMemReset", 64'(mem_reset), 64'(1));
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("wrd.noRsp%0d", c), 64'(rsp_valid), 64'(0));
      @(negedge clk);
      #1;
    end
    reset = 1'b1;
    rwBus = '1; modeBus = {NREQ{3'b001}}; dinBus = '0;
    applyStimulus(4'b0101, rwBus, modeBus, dinBus, grantVec, rspVec, gotErr, gotData, gotLat, gotResets, gotRw);
    checkOutput("wrd.firstGrant", 64'(grantVec), 64'(4'b0001));
    checkOutput("wrd.firstErr", 64'(gotErr), 64'(1));
    checkOutput("wrd.firstLatency", 64'(gotLat), 64'(2));

    // Random traffic against the reference model.
    modelQ.delete();
    modelCur = 3'b000;
    modelRr  = 0;
    for (int t = 0; t < 200; t++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r == 0)      rwBus[2*i +: 2] = 2'b11;
        else if (r == 1) rwBus[2*i +: 2] = 2'b00;
        else if (r < 11) rwBus[2*i +: 2] = 2'b01;
        else             rwBus[2*i +: 2] = 2'b10;
        r = $urandom_range(0, 19);
        if (r == 0)                          modeBus[3*i +: 3] = 3'b110;
        else if (r < 15 && modelCur != 3'b0) modeBus[3*i +: 3] = modelCur;
        else                                 modeBus[3*i +: 3] = 3'(3'b001 << $urandom_range(0, 2));
        dinBus[WIDTH*i +: WIDTH] = $urandom;
      end
      expIdx = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (modelRr + k) % NREQ;
        if (expIdx < 0 && mask[j]) expIdx = j;
      end
      modelRr = expIdx;
      modelTxn(rwBus[2*expIdx +: 2], modeBus[3*expIdx +: 3], dinBus[WIDTH*expIdx +: WIDTH], expErr, expData, expLat);
      applyStimulus(mask, rwBus, modeBus, dinBus, grantVec, rspVec, gotErr, gotData, gotLat, gotResets, gotRw);
      checkOutput($sformatf("rnd%0d.grant", t), 64'(grantVec), 64'(NREQ'(1) << expIdx));
      checkOutput($sformatf("rnd%0d.rspValid", t), 64'(rspVec), 64'(NREQ'(1) << expIdx));
      checkOutput($sformatf("rnd%0d.err", t), 64'(gotErr), 64'(expErr));
      checkOutput($sformatf("rnd%0d.data", t), 64'(gotData), 64'(expData));
      checkOutput($sformatf("rnd%0d.latency", t), 64'(gotLat), 64'(expLat));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_cell_arbiter.md
Name: mem_cell_arbiter

Overview:
- Shares one mem_cell (buffer/FIFO/LIFO storage, one-hot mode and chip_en, 2-bit rw) between NREQ requesters.
- Grants requesters round-robin and checks each request against full/empty and the current mode.
- Sequences mode switches by flushing the mem_cell through its reset.
- Drives the mem_cell ports directly and returns read data and status per requester. Only one transaction is outstanding at a time.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 32: data width of Din/Dout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets the block).
- req_valid  in  NREQ  request pending, one bit per requester.
- req_rw  in  2*NREQ  per requester: 01 = write, 10 = read.
- req_mode  in  3*NREQ  per requester, one-hot: 001 = buffer, 010 = FIFO, 100 = LIFO.
- req_din  in  WIDTH*NREQ  per-requester write data.
- req_ready  out  NREQ  one-cycle accept pulse to the granted requester.
- rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester.
- rsp_data  out  WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  request rejected, valid with rsp_valid.
- mem_Din  out  WIDTH  to mem_cell Din.
- mem_mode_in  out  3  to mem_cell mode_in.
- mem_chip_en  out  3  to mem_cell chip_en.
- mem_rw  out  2  to mem_cell rw.
- mem_reset  out  1  to mem_cell reset (active-high).
- mem_Dout  in  WIDTH  from mem_cell Dout.
- mem_full  in  1  from mem_cell full.
- mem_empty  in  1  from mem_cell empty.

Behaviour:
- Reset (reset=0, async):
  - State goes to INIT; cur_mode=000; rr_ptr=NREQ-1.
  - All outputs are 0 except mem_reset=1.
  - An in-flight transaction is dropped with no rsp_valid.
- mem_reset = ~reset OR state in {INIT, SWITCH}.
- mem_mode_in = cur_mode at all times except in SWITCH.
- mem_chip_en = cur_mode only in EXEC and WAIT_RD, else 000.
- mem_rw = 00 outside EXEC.
- Requester protocol: hold req_valid and payload stable until req_ready. Deasserting req_valid before grant withdraws the request.
- FSM states and transitions:
  - INIT: one cycle after reset release -> IDLE.
  - IDLE: if any req_valid, pick the first set bit scanning from rr_ptr+1 upward with wrap.
    - Pulse req_ready[i].
    - Latch idx=i, rw, mode, din; set rr_ptr=i.
    - -> CHECK. No request: stay.
  - CHECK: evaluate in priority order:
    - mode not one-hot, or rw in {00,11} -> RESP with err.
    - mode != cur_mode and mem_empty=0 -> RESP with err. A mode switch is allowed only when the mem_cell is empty.
    - mode != cur_mode and mem_empty=1 -> SWITCH.
    - write and mem_full=1 -> RESP with err.
    - read and mem_empty=1 -> RESP with err.
    - otherwise -> EXEC.
  - SWITCH: mem_reset=1 and mem_mode_in=latched mode for one cycle; cur_mode<=mode; -> EXEC.
  - EXEC: mem_rw=latched rw, mem_Din=latched din, mem_chip_en=cur_mode for one cycle. Write -> RESP; read -> WAIT_RD.
  - WAIT_RD: the mem_cell presents Dout one cycle after the read edge. Capture mem_Dout into rsp_data -> RESP.
  - RESP: rsp_valid[idx]=1 for one cycle.
    - rsp_err=1 on reject, else 0.
    - rsp_data = captured data on a successful read, else 0.
    - -> IDLE.
- Latency from the req_ready cycle T:
  - write OK: rsp at T+3.
  - read OK: rsp at T+4.
  - mode switch: +1 cycle.
  - reject: rsp at T+2.
- req_ready cannot reassert until the cycle after RESP. Minimum grant spacing is 3 cycles (reject) or 4 cycles (write).
- Fairness: a continuously requesting requester is granted within NREQ grants.
- Full/empty are sampled only in CHECK. Values in other states are ignored.

Test Plan:
- Reset low for 2 cycles then high: all outputs 0, mem_reset=1 through INIT, then 0. No req_ready while reset=0.
- Req0 writes FIFO (mode 010) data 1,2,3, then three reads:
  - First write goes through SWITCH.
  - rsp_data = 1, 2, 3 in order, rsp_err=0.
  - Write rsp at T+4 (switch), later writes at T+3, reads at T+4.
- Req1 writes LIFO 1,2,3 after the FIFO drains, then three reads: one SWITCH (mem_reset pulse); rsp_data = 3, 2, 1.
- FIFO holds 1 entry; req2 requests a LIFO write: rsp_err=1 at T+2, cur_mode stays 010, no mem_reset pulse, stored entry is still readable.
- Reject cases:
  - Read with mem_empty=1 -> rsp_err=1, mem_rw never 10.
  - Write with mem_full=1 -> rsp_err=1.
  - mode=110 or rw=11 -> rsp_err=1.
- All 4 requesters hold req_valid: grant order 0,1,2,3,0. Pull reset low during WAIT_RD: no rsp_valid; after release rr_ptr=3, so requester 0 is granted first.
